arp_sequencer: RTL and testbench

- Step scheduler for the synthesizer note datapath. It turns the set of currently held keys into a timed sequence of single notes, one note per step.
- Each issued note is a key index plus a strobe pulse. The downstream divider lookup and sound driver consume these exactly as they would a single held key.
- Sits between the keypad conditioning logic and the divider/PWM datapath. It is enabled when the team's arpeggio play mode is selected.

---
 rtl/arp_sequencer_if.sv | 25 ++
 rtl/arp_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_arp_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_sequencer_if.sv
// Key-set input and note output bundle between the keypad conditioning logic and the arpeggiator.
interface arp_sequencer_if #(
   parameter int unsigned NUM_KEYS = 13,
   parameter int unsigned PERIOD_W = 16
);
   localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   logic [NUM_KEYS-1:0] keys;
   logic [1:0]          arp_mode;
   logic [PERIOD_W-1:0] step_period;
   logic                latch_clr;
   logic [IDX_W-1:0]    note_idx;
   logic                note_valid;
   logic                note_strobe;

   modport master (
      output keys, arp_mode, step_period, latch_clr,
      input  note_idx, note_valid, note_strobe
   );

   modport slave (
      input  keys, arp_mode, step_period, latch_clr,
      output note_idx, note_valid, note_strobe
   );
endinterface

// File: rtl/arp_sequencer.sv
// Arpeggiator step scheduler: issues one held key per step in up, down or bounce order.
// Define ARP_LATCH_EN to play from a latched key set that survives key release.
module arp_sequencer #(
   parameter int unsigned NUM_KEYS = 13,
   parameter int unsigned PERIOD_W = 16
) (
   input logic           clk,
   input logic           rst,
   arp_sequencer_if.slave bus
);
   localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;

   typedef enum logic {IDLE, PLAY} state_t;

   state_t              state;
   logic [PERIOD_W-1:0] cnt;
   logic                dir_up;
   logic [IDX_W-1:0]    note_idx;
   logic                note_valid;
   logic                note_strobe;

   logic [NUM_KEYS-1:0] act_c;
   logic [PERIOD_W-1:0] per_m1_c;
   logic                tick_c;
   logic [IDX_W:0]      above_c, below_c;
   logic [IDX_W-1:0]    lo_c, hi_c, nxt_idx_c;
   logic                nxt_dir_up_c;

   // Lowest set index strictly above cur; MSB flags a hit.
   function automatic logic [IDX_W:0] find_above(input logic [NUM_KEYS-1:0] set,
                                                 input logic [IDX_W-1:0] cur);
      logic [IDX_W:0] r;
      r = '0;
      for (int i = int'(NUM_KEYS) - 1; i >= 0; i--)
         if (set[i] && (IDX_W'(i) > cur)) r = {1'b1, IDX_W'(i)};
      return r;
   endfunction

   function automatic logic [IDX_W:0] find_below(input logic [NUM_KEYS-1:0] set,
                                                 input logic [IDX_W-1:0] cur);
      logic [IDX_W:0] r;
      r = '0;
      for (int i = 0; i < int'(NUM_KEYS); i++)
         if (set[i] && (IDX_W'(i) < cur)) r = {1'b1, IDX_W'(i)};
      return r;
   endfunction

   function automatic logic [IDX_W-1:0] find_lowest(input logic [NUM_KEYS-1:0] set);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = int'(NUM_KEYS) - 1; i >= 0; i--)
         if (set[i]) r = IDX_W'(i);
      return r;
   endfunction

   function automatic logic [IDX_W-1:0] find_highest(input logic [NUM_KEYS-1:0] set);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(NUM_KEYS); i++)
         if (set[i]) r = IDX_W'(i);
      return r;
   endfunction

`ifdef ARP_LATCH_EN
   logic [NUM_KEYS-1:0] latched, keys_prev, latched_nxt_c;

   // A fresh press after full release starts a new chord; otherwise keys accumulate.
   always_comb begin
      latched_nxt_c = latched;
      if (bus.keys != '0)
         latched_nxt_c = ((keys_prev == '0) || bus.latch_clr) ? bus.keys : (latched | bus.keys);
      else if (bus.latch_clr)
         latched_nxt_c = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         latched   <= '0;
         keys_prev <= '0;
      end else begin
         latched   <= latched_nxt_c;
         keys_prev <= bus.keys;
      end
   end

   assign act_c = latched_nxt_c;
`else
   logic unused_latch_clr;
   assign unused_latch_clr = bus.latch_clr;
   assign act_c = bus.keys;
`endif

   assign per_m1_c = (bus.step_period == '0) ? '0 : bus.step_period - PERIOD_W'(1);
   assign tick_c   = (cnt >= per_m1_c);
   assign above_c  = find_above(act_c, note_idx);
   assign below_c  = find_below(act_c, note_idx);
   assign lo_c     = find_lowest(act_c);
   assign hi_c     = find_highest(act_c);

   // Next note relative to the current index; search ignores whether that key is still held.
   always_comb begin
      nxt_idx_c    = note_idx;
      nxt_dir_up_c = dir_up;
      case (bus.arp_mode)
         MODE_DOWN: begin
            nxt_dir_up_c = 1'b0;
            nxt_idx_c    = below_c[IDX_W] ? below_c[IDX_W-1:0] : hi_c;
         end
         MODE_BOUNCE: begin
            if (dir_up) begin
               if (above_c[IDX_W]) nxt_idx_c = above_c[IDX_W-1:0];
               else if (below_c[IDX_W]) begin
                  nxt_idx_c    = below_c[IDX_W-1:0];
                  nxt_dir_up_c = 1'b0;
               end
            end else begin
               if (below_c[IDX_W]) nxt_idx_c = below_c[IDX_W-1:0];
               else if (above_c[IDX_W]) begin
                  nxt_idx_c    = above_c[IDX_W-1:0];
                  nxt_dir_up_c = 1'b1;
               end
            end
         end
         default: begin
            nxt_dir_up_c = 1'b1;
            nxt_idx_c    = above_c[IDX_W] ? above_c[IDX_W-1:0] : lo_c;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         dir_up      <= 1'b1;
         note_idx    <= '0;
         note_valid  <= 1'b0;
         note_strobe <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               note_strobe <= 1'b0;
               cnt         <= '0;
               if (act_c != '0) begin
                  state       <= PLAY;
                  note_valid  <= 1'b1;
                  note_strobe <= 1'b1;
                  if (bus.arp_mode == MODE_DOWN) begin
                     note_idx <= hi_c;
                     dir_up   <= 1'b0;
                  end else begin
                     note_idx <= lo_c;
                     dir_up   <= 1'b1;
                  end
               end
            end
            default: begin
               // Release beats a coincident tick.
               if (act_c == '0) begin
                  state       <= IDLE;
                  note_valid  <= 1'b0;
                  note_strobe <= 1'b0;
                  cnt         <= '0;
               end else if (tick_c) begin
                  cnt         <= '0;
                  note_idx    <= nxt_idx_c;
                  dir_up      <= nxt_dir_up_c;
                  note_strobe <= 1'b1;
               end else begin
                  cnt         <= cnt + PERIOD_W'(1);
                  note_strobe <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.note_idx    = note_idx;
   assign bus.note_valid  = note_valid;
   assign bus.note_strobe = note_strobe;
endmodule

// File: tb/tb_arp_sequencer.sv
// Self-checking bench for arp_sequencer: vector table, corner sequences and random stimulus vs. a set-based model.
module tb_arp_sequencer;
   localparam int unsigned NK = 13;
   localparam int unsigned PW = 16;

   logic clk = 1'b0;
   logic rst;

   arp_sequencer_if #(.NUM_KEYS(NK), .PERIOD_W(PW)) bus ();
   arp_sequencer #(.NUM_KEYS(NK), .PERIOD_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc_no = 0;

   // Model: "since" counts cycles since the last strobe; notes chosen from the sorted list of held keys.
   bit m_play, m_valid, m_strobe, m_dir_up;
   int m_idx, m_since;
`ifdef ARP_LATCH_EN
   logic [NK-1:0] m_latched, m_kprev;
`endif

   typedef struct packed {
      logic [NK-1:0] keys;
      logic [1:0]    mode;
      logic [PW-1:0] per;
      logic [3:0]    n;
      logic [31:0]   seq;   // nibble k = k-th expected note
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   task automatic model_pick(input logic [NK-1:0] set, input int mode);
      int q[$];
      int above, below;
      above = -1;
      below = -1;
      for (int i = 0; i < int'(NK); i++) if (set[i]) q.push_back(i);
      foreach (q[k]) begin
         if (q[k] > m_idx && above < 0) above = q[k];
         if (q[k] < m_idx) below = q[k];
      end
      if (mode == 1) begin
         m_dir_up = 0;
         m_idx = (below >= 0) ? below : q[q.size()-1];
      end else if (mode == 2) begin
         if (m_dir_up) begin
            if (above >= 0) m_idx = above;
            else if (below >= 0) begin m_idx = below; m_dir_up = 0; end
         end else begin
            if (below >= 0) m_idx = below;
            else if (above >= 0) begin m_idx = above; m_dir_up = 1; end
         end
      end else begin
         m_dir_up = 1;
         m_idx = (above >= 0) ? above : q[0];
      end
   endtask

   task automatic model_edge();
      logic [NK-1:0] act;
      int per;
      if (rst) begin
         m_play = 0; m_valid = 0; m_strobe = 0; m_dir_up = 1; m_idx = 0; m_since = 0;
`ifdef ARP_LATCH_EN
         m_latched = '0; m_kprev = '0;
`endif
         return;
      end
`ifdef ARP_LATCH_EN
      if (bus.keys != '0)
         m_latched = (m_kprev == '0 || bus.latch_clr) ? bus.keys : (m_latched | bus.keys);
      else if (bus.latch_clr)
         m_latched = '0;
      m_kprev = bus.keys;
      act = m_latched;
`else
      act = bus.keys;
`endif
      per = (bus.step_period == '0) ? 1 : int'(bus.step_period);
      if (!m_play) begin
         m_strobe = 0;
         if (act != '0) begin
            m_play = 1; m_valid = 1; m_strobe = 1; m_since = 0;
            m_dir_up = (bus.arp_mode != 2'd1);
            m_idx = 0;
            for (int i = 0; i < int'(NK); i++)
               if (act[i] && (bus.arp_mode == 2'd1 || m_idx == 0 && !act[m_idx])) m_idx = i;
            if (bus.arp_mode != 2'd1)
               for (int i = int'(NK) - 1; i >= 0; i--) if (act[i]) m_idx = i;
         end
      end else if (act == '0) begin
         m_play = 0; m_valid = 0; m_strobe = 0; m_since = 0;
      end else begin
         m_since++;
         if (m_since >= per) begin
            m_since = 0;
            m_strobe = 1;
            model_pick(act, int'(bus.arp_mode));
         end else m_strobe = 0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      cyc_no++;
      #1;
      check("model_valid",  int'(bus.note_valid),  int'(m_valid));
      check("model_strobe", int'(bus.note_strobe), int'(m_strobe));
      check("model_idx",    int'(bus.note_idx),    m_idx);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      bus.keys = '0;
      bus.latch_clr = 1'b0;
      repeat (n) cyc();
      rst = 1'b0;
   endtask

   task automatic run_until_strobe(input string name, input int exp_idx);
      bit got;
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         cyc();
         if (bus.note_strobe) got = 1;
      end
      check({name, "_strobe_seen"}, int'(got), 1);
      if (got) check({name, "_idx"}, int'(bus.note_idx), exp_idx);
   endtask

   initial begin
      int nstb, held;
      rst = 1'b1;
      bus.keys = '0;
      bus.arp_mode = 2'd0;
      bus.step_period = PW'(4);
      bus.latch_clr = 1'b0;

      vecs[0] = '{keys: 13'h0025, mode: 2'd0, per: 16'd4, n: 4'd5, seq: 32'h0002_0520};
      vecs[1] = '{keys: 13'h0092, mode: 2'd2, per: 16'd3, n: 4'd7, seq: 32'h0741_4741};
      vecs[2] = '{keys: 13'h0208, mode: 2'd1, per: 16'd0, n: 4'd4, seq: 32'h0000_3939};
      vecs[3] = '{keys: 13'h1001, mode: 2'd3, per: 16'd2, n: 4'd4, seq: 32'h0000_C0C0};
      vecs[4] = '{keys: 13'h0040, mode: 2'd2, per: 16'd1, n: 4'd4, seq: 32'h0000_6666};
      vecs[5] = '{keys: 13'h1001, mode: 2'd2, per: 16'd2, n: 4'd4, seq: 32'h0000_C0C0};
      vecs[6] = '{keys: 13'h0824, mode: 2'd1, per: 16'd3, n: 4'd5, seq: 32'h0005_B25B};

      // Reset, then idle with no keys
      do_reset(2);
      check("rst_idx", int'(bus.note_idx), 0);
      check("rst_valid", int'(bus.note_valid), 0);
      check("rst_strobe", int'(bus.note_strobe), 0);
      nstb = 0;
      repeat (100) begin cyc(); if (bus.note_strobe) nstb++; end
      check("idle_no_strobe", nstb, 0);

      // Vector table
      for (int v = 0; v < NV; v++) begin
         int seen, last, pe;
         do_reset(2);
         bus.keys = vecs[v].keys;
         bus.arp_mode = vecs[v].mode;
         bus.step_period = vecs[v].per;
         pe = (vecs[v].per == '0) ? 1 : int'(vecs[v].per);
         seen = 0;
         last = 0;
         for (int c = 1; c <= 80 && seen < int'(vecs[v].n); c++) begin
            cyc();
            if (bus.note_strobe) begin
               if (seen == 0) check($sformatf("v%0d_first_latency", v), c, 1);
               else check($sformatf("v%0d_spacing", v), c - last, pe);
               check($sformatf("v%0d_note%0d", v, seen), int'(bus.note_idx),
                     int'(vecs[v].seq[4*seen +: 4]));
               last = c;
               seen++;
            end
         end
         check($sformatf("v%0d_strobe_count", v), seen, int'(vecs[v].n));
      end

      // Bounce then release: valid drops next cycle, index holds
      do_reset(2);
      bus.arp_mode = 2'd2; bus.step_period = PW'(3); bus.keys = 13'h0092;
      repeat (8) cyc();
      held = m_idx;
      bus.keys = '0;
      cyc();
      check("release_valid", int'(bus.note_valid), 0);
      check("release_strobe", int'(bus.note_strobe), 0);
      check("release_idx_hold", int'(bus.note_idx), held);

      // Period shrink mid-step with single key retrigger
      do_reset(2);
      bus.arp_mode = 2'd0; bus.step_period = PW'(10); bus.keys = 13'h0040;
      cyc();
      check("shrink_first_strobe", int'(bus.note_strobe), 1);
      repeat (7) cyc();
      check("shrink_pre_strobe", int'(bus.note_strobe), 0);
      bus.step_period = PW'(5);
      cyc();
      check("shrink_tick_next", int'(bus.note_strobe), 1);
      check("shrink_retrig_idx", int'(bus.note_idx), 6);
      for (int k = 1; k <= 5; k++) begin
         cyc();
         check($sformatf("shrink_after_%0d", k), int'(bus.note_strobe), (k == 5) ? 1 : 0);
      end

      // Tick coincident with release
      bus.step_period = PW'(1); bus.keys = 13'h0021;
      repeat (3) cyc();
      check("per1_strobe_high", int'(bus.note_strobe), 1);
      bus.keys = '0;
      cyc();
      check("tick_release_strobe", int'(bus.note_strobe), 0);
      check("tick_release_valid", int'(bus.note_valid), 0);

      // Reset mid-step with keys held
      bus.keys = 13'h0021; bus.step_period = PW'(3);
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      check("midrst_strobe", int'(bus.note_strobe), 0);
      check("midrst_valid", int'(bus.note_valid), 0);
      check("midrst_idx", int'(bus.note_idx), 0);
      cyc();
      check("midrst_hold_strobe", int'(bus.note_strobe), 0);
      rst = 1'b0;
      cyc();
      check("midrst_restart_strobe", int'(bus.note_strobe), 1);

`ifdef ARP_LATCH_EN
      // Latched set survives release, new chord replaces it, clear stops play
      do_reset(2);
      bus.arp_mode = 2'd0; bus.step_period = PW'(2); bus.keys = 13'h0024;
      cyc();
      check("latch_first_idx", int'(bus.note_idx), 2);
      bus.keys = '0;
      run_until_strobe("latch_second", 5);
      run_until_strobe("latch_third", 2);
      bus.keys = 13'h0100;
      cyc();
      bus.keys = '0;
      run_until_strobe("latch_new_a", 8);
      run_until_strobe("latch_new_b", 8);
      bus.latch_clr = 1'b1;
      cyc();
      bus.latch_clr = 1'b0;
      check("latch_clr_valid", int'(bus.note_valid), 0);
`else
      do_reset(2);
      bus.arp_mode = 2'd0; bus.step_period = PW'(2); bus.keys = 13'h0024;
      run_until_strobe("nolatch_first", 2);
      bus.keys = '0;
      cyc();
      check("nolatch_release_valid", int'(bus.note_valid), 0);
`endif

      // Randomised stimulus against the model
      do_reset(2);
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 9) == 0)
            bus.keys = ($urandom_range(0, 3) == 0) ? '0 : NK'($urandom);
         if ($urandom_range(0, 30) == 0) bus.arp_mode = 2'($urandom);
         if ($urandom_range(0, 40) == 0) bus.step_period = PW'($urandom_range(0, 5));
         bus.latch_clr = ($urandom_range(0, 40) == 0);
         rst = ($urandom_range(0, 300) == 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
